// File: rtl/riscv_pkg.sv
// Shared fetch definitions: XLEN, the reset PC default, the NOP encoding,
// the fetch FSM state enum and a word-alignment helper.
package riscv_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_WAIT = 2'd2,
        FS_DROP = 2'd3
    } fetch_state_e;

    // Clear the byte-offset bits so a fetch address is always word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH x WIDTH synchronous FIFO with flush. The head entry is read
// combinationally from registered storage. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush wins over push and pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    // Storage needs no reset: an entry is only read once it is counted valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues single-outstanding word fetches,
// buffers responses in a small FIFO and handles redirects.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (sticky misalign flag that
// stalls fetching on an unaligned redirect target).
//
// state | meaning
// IDLE  | first cycle after reset, no request
// REQ   | present fetch_pc, request while the buffer has room
// WAIT  | one request granted, waiting for its response
// DROP  | granted request made stale by a redirect, discard its response
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    output logic            misalign
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CW1 = CW + 1;

    localparam logic [1:0] ST_IDLE = FS_IDLE;
    localparam logic [1:0] ST_REQ  = FS_REQ;
    localparam logic [1:0] ST_WAIT = FS_WAIT;
    localparam logic [1:0] ST_DROP = FS_DROP;

    logic [1:0]        state;
    logic [1:0]        state_n;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   redirect_target;
    logic [1:0]        ign_cnt;
    logic              rvalid_ok;
    logic              outstanding;
    logic              space_ok;
    logic [XLEN-1:0]   hold_instr;
    logic [XLEN-1:0]   hold_pc;
    logic              fifo_push;
    logic              fifo_pop;
    logic [2*XLEN-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    // Sticky until the next redirect; an aligned target clears it.
    always_ff @(posedge clk) begin
        if (rst)           misalign_q <= 1'b0;
        else if (redirect) misalign_q <= |redirect_pc[1:0];
    end

    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    assign redirect_target = word_align(redirect_pc);

    // A response left over from before reset may still arrive; ignore rvalid
    // for the first two cycles after reset.
    assign rvalid_ok   = imem_rvalid && (ign_cnt == 2'd0);
    assign outstanding = (state == ST_WAIT) || (state == ST_DROP);
    assign space_ok    = ({1'b0, fifo_count} + CW1'(outstanding)) < CW1'(DEPTH);
    assign imem_req    = (state == ST_REQ) && space_ok && !misalign;
    assign imem_addr   = fetch_pc;

    assign fifo_push = (state == ST_WAIT) && rvalid_ok && !redirect
                       && (!fifo_full || fifo_pop);
    assign fifo_pop  = instr_valid && instr_ready && !redirect;

    assign instr_valid = !fifo_empty;
    assign instr       = fifo_empty ? hold_instr : fifo_head[XLEN-1:0];
    assign instr_pc    = fifo_empty ? hold_pc    : fifo_head[2*XLEN-1:XLEN];

    // Next-state selection; a redirect only changes where a live response goes.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: state_n = ST_REQ;
            ST_REQ:  if (imem_req && imem_gnt) state_n = redirect ? ST_DROP : ST_WAIT;
            ST_WAIT: begin
                if (redirect)       state_n = rvalid_ok ? ST_REQ : ST_DROP;
                else if (rvalid_ok) state_n = ST_REQ;
            end
            ST_DROP: if (rvalid_ok) state_n = ST_REQ;
            default: state_n = ST_REQ;
        endcase
    end

    // State, fetch address, reset-ignore timer and last-shown instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            fetch_pc   <= RESET_PC;
            ign_cnt    <= 2'd2;
            hold_instr <= NOP_INSTR;
            hold_pc    <= '0;
        end else begin
            state <= state_n;
            if (ign_cnt != 2'd0) ign_cnt <= ign_cnt - 2'd1;
            if (redirect)                    fetch_pc <= redirect_target;
            else if (imem_req && imem_gnt)   fetch_pc <= fetch_pc + 32'd4;
            if (!fifo_empty) begin
                hold_instr <= fifo_head[XLEN-1:0];
                hold_pc    <= fifo_head[2*XLEN-1:XLEN];
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (fifo_push),
        .push_data ({fetch_pc - 32'd4, imem_rdata}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 2: instruction buffer entries, legal range 2..4.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 imem_req  out  1  fetch request to instruction memory.
REQ-006 imem_addr  out  32  word-aligned fetch address, valid while imem_req=1.
REQ-007 imem_gnt  in  1  memory accepted the request this cycle.
REQ-008 imem_rvalid  in  1  read data valid this cycle.
REQ-009 imem_rdata  in  32  fetched instruction word.
REQ-010 redirect  in  1  control-flow change: branch taken or jump.
REQ-011 redirect_pc  in  32  new fetch address, sampled when redirect=1.
REQ-012 instr_valid  out  1  instr and instr_pc hold a buffered instruction.
REQ-013 instr  out  32  instruction word delivered to the decoder.
REQ-014 instr_pc  out  32  address of instr.
REQ-015 instr_ready  in  1  decoder consumes the instruction this cycle.
REQ-016 misalign  out  1  sticky flag: redirect target not word-aligned.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, DROP; IDLE exists only for the first cycle after reset, then REQ.
REQ-018 REQ: imem_req=1 only if (buffer count + outstanding) < DEPTH; imem_addr=fetch_pc; hold addr stable until imem_gnt.
REQ-019 REQ with imem_gnt=1: fetch_pc += 4 (mod 2^32, wrap from FFFF_FFFC to 0); go to WAIT.
REQ-020 At most one outstanding request; imem_req=0 in WAIT and DROP.
REQ-021 WAIT with imem_rvalid=1: push {pc, rdata} into buffer; return to REQ; a new request may be issued the following cycle.
REQ-022 Latency: gnt in cycle N, rvalid in N+1 earliest, instr_valid=1 in N+2 (registered buffer output).
REQ-023 Buffer is FIFO; pop when instr_valid && instr_ready; instr/instr_pc show head entry; push and pop in the same cycle allowed when full.
REQ-024 instr_valid=0 whenever buffer is empty; instr/instr_pc hold their last value then.
REQ-025 redirect has priority over all other events: buffer flushed, pop in the same cycle ignored, fetch_pc=redirect_pc next cycle.
REQ-026 redirect in WAIT without rvalid in the same cycle: go to DROP; discard the next rvalid, then go to REQ.
REQ-027 redirect in the same cycle as rvalid: that response dropped, go to REQ.
REQ-028 redirect in REQ before gnt: request withdrawn, new address presented next cycle; redirect with gnt in the same cycle: treat as outstanding, go to DROP.
REQ-029 instr_valid=0 in the cycle after a redirect.

Reset
REQ-030 On rst: fetch_pc=RESET_PC, state=IDLE, buffer empty, outstanding=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=0, misalign=0.
REQ-031 rst during WAIT: pending response forgotten; any rvalid arriving in the first 2 cycles after reset is ignored.

Configuration
REQ-032 Macro FETCH_MISALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 sets misalign, stops requests until the next aligned redirect or rst; misalign clears on aligned redirect.
REQ-033 Macro not defined: redirect_pc[1:0] forced to 0; misalign tied 0.

Structure
REQ-034 Shared package riscv_pkg holds RESET_PC default, NOP encoding 32'h0000_0013, fetch FSM state enum, XLEN=32.
REQ-035 Sub-module fetch_fifo: parameterised DEPTH x 64-bit synchronous FIFO with flush, push, pop, full, empty, count.

Verification
REQ-036 Reset, gnt same cycle, rvalid +1, instr_ready=1 -> instr_pc sequence 0,4,8 with instr_valid from cycle 3.
REQ-037 instr_ready=0 held -> exactly DEPTH fetches, then imem_req=0; ready=1 -> fetching resumes, order preserved.
REQ-038 redirect to 0x100 while WAIT, rvalid next cycle -> that data dropped; next imem_addr=0x100; first instr_pc=0x100.
REQ-039 redirect coinciding with pop and rvalid -> buffer empty, instr_valid=0 next cycle, no duplicate or lost-order instruction.
REQ-040 fetch_pc=FFFF_FFFC granted -> next imem_addr=0000_0000.
REQ-041 With FETCH_MISALIGN_CHECK_EN, redirect_pc=0x102 -> misalign=1, imem_req=0; redirect 0x200 -> misalign=0, imem_addr=0x200.
